mdu_iter: RTL and testbench



---
 rtl/rv_mdu_pkg.sv | 27 ++
 rtl/mdu_iter.sv | 152 +++++++++++++++
 tb/tb_mdu_iter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/rv_mdu_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// operand width, funct3 encodings, FSM state type and op-class helper.
package rv_mdu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // Divide and remainder ops all have funct3[2] set.
    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit.
// Accepts an op on start (IDLE only), runs 32 shift-add or restoring-divide
// steps on operand magnitudes, applies the sign fix-up and pulses done.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start          request, honoured only in IDLE
//   funct3         RV32M operation select
//   src_a, src_b   rs1 / rs2 operands
//   busy           operation in flight (CALC or FIN)
//   done           one-cycle pulse, result valid
//   result         registered result, held until the next completion
module mdu_iter
    import rv_mdu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned AW = 2 * XLEN;
    localparam int unsigned CW = 5;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt;
    logic [2:0]        op;
    logic              sign_a, sign_b;
    logic [AW-1:0]     acc;     // multiply {hi, multiplier}; divide {remainder, quotient}
    logic [XLEN-1:0]   opb;     // multiplicand / divisor magnitude

    // Operand classification at acceptance.
    logic            sa_c, sb_c, div_zero_c, div_ovf_c, special_c;
    logic [XLEN-1:0] mag_a_c, mag_b_c;

    always_comb begin
        sa_c       = (funct3 != F3_MULHU) && (funct3 != F3_DIVU) && (funct3 != F3_REMU);
        sb_c       = (funct3 == F3_MUL) || (funct3 == F3_MULH) ||
                     (funct3 == F3_DIV) || (funct3 == F3_REM);
        mag_a_c    = (sa_c && src_a[XLEN-1]) ? -src_a : src_a;
        mag_b_c    = (sb_c && src_b[XLEN-1]) ? -src_b : src_b;
        div_zero_c = is_div(funct3) && (src_b == '0);
        div_ovf_c  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                     (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (src_b == '1);
        special_c  = div_zero_c || div_ovf_c;
    end

    // One multiply step: conditional add into the high half, then shift right.
    logic [XLEN:0]   mul_sum;
    logic [AW-1:0]   mul_acc;
    // One restoring divide step on the left-shifted remainder.
    logic [XLEN:0]   rem_sh;
    logic            div_ge;
    logic [AW-1:0]   div_acc;

    always_comb begin
        mul_sum = {1'b0, acc[AW-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
        mul_acc = {mul_sum, acc[XLEN-1:1]};
        rem_sh  = {acc[AW-1:XLEN], acc[XLEN-1]};
        div_ge  = rem_sh >= {1'b0, opb};
        div_acc = {(div_ge ? (rem_sh[XLEN-1:0] - opb) : rem_sh[XLEN-1:0]),
                   acc[XLEN-2:0], div_ge};
    end

    // Sign fix-up and result select.
    logic [AW-1:0]   prod_c;
    logic [XLEN-1:0] quo_c, rem_c, fin_c;

    always_comb begin
        prod_c = (sign_a ^ sign_b) ? -acc : acc;
        quo_c  = (sign_a ^ sign_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem_c  = sign_a ? -acc[AW-1:XLEN] : acc[AW-1:XLEN];
        case (op)
            F3_MUL:                       fin_c = prod_c[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fin_c = prod_c[AW-1:XLEN];
            F3_DIV, F3_DIVU:              fin_c = quo_c;
            default:                      fin_c = rem_c;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = special_c ? ST_FIN : ST_CALC;
            ST_CALC: if (cnt == CW'(31)) state_nxt = ST_FIN;
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            op     <= F3_MUL;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            acc    <= '0;
            opb    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            busy <= (state_nxt != ST_IDLE);
            done <= (state == ST_FIN);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op  <= funct3;
                        cnt <= '0;
                        opb <= mag_b_c;
                        if (div_zero_c) begin
                            // Quotient all-ones, remainder = dividend, no fix-up.
                            sign_a <= 1'b0;
                            sign_b <= 1'b0;
                            acc    <= {src_a, {XLEN{1'b1}}};
                        end else if (div_ovf_c) begin
                            // Overflow: quotient = most-negative, remainder 0.
                            sign_a <= 1'b0;
                            sign_b <= 1'b0;
                            acc    <= {{XLEN{1'b0}}, src_a};
                        end else begin
                            sign_a <= sa_c && src_a[XLEN-1];
                            sign_b <= sb_c && src_b[XLEN-1];
                            acc    <= {{XLEN{1'b0}}, mag_a_c};
                        end
                    end
                end
                ST_CALC: begin
                    acc <= is_div(op) ? div_acc : mul_acc;
                    cnt <= cnt + CW'(1);
                end
                ST_FIN: begin
                    result <= fin_c;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter.
module tb_mdu_iter;
    import rv_mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int failures = 0;

    mdu_iter dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .src_a  (src_a),
        .src_b  (src_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the done cycle (or on timeout).
    task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int   n;
        logic busy_ok;
        start = 1'b1; funct3 = f; src_a = a; src_b = b;
        @(negedge clk);
        // Scramble inputs after acceptance; they must not matter.
        start = 1'b0; funct3 = ~f; src_a = ~a; src_b = b + 32'd1;
        n = 0; busy_ok = 1'b1;
        while (done !== 1'b1 && n < 60) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
        chk({tag, "_result"}, {32'd0, result}, {32'd0, exp});
        chk({tag, "_busy_while_calc"}, {63'd0, busy_ok}, 64'd1);
        chk({tag, "_busy_in_done"}, {63'd0, busy}, 64'd0);
    endtask

    task automatic op_idle(input string tag, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        do_op(tag, f, a, b, exp, exp_lat);
        @(negedge clk);
        chk({tag, "_done_drop"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        int          ndone;
        logic [31:0] first_res;

        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_result", {32'd0, result}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        op_idle("mul",    F3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        op_idle("mulh",   F3_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33);
        op_idle("mulhu",  F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        op_idle("mulhsu", F3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        op_idle("div",    F3_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33);
        op_idle("rem",    F3_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33);
        op_idle("divu",   F3_DIVU,   32'd100,        32'd7,         32'd14,        33);
        op_idle("remu",   F3_REMU,   32'd100,        32'd7,         32'd2,         33);
        op_idle("rem_nb", F3_REM,    32'd7,          32'hFFFF_FFFE, 32'd1,         33);
        op_idle("div0",   F3_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1);
        op_idle("remu0",  F3_REMU,   32'd5,          32'd0,         32'd5,         1);
        op_idle("divovf", F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
        op_idle("removf", F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);

        // Back-to-back: second start issued in the done cycle of the first.
        do_op("b2b_first", F3_MUL, 32'd6, 32'd7, 32'd42, 33);
        op_idle("b2b_second", F3_DIVU, 32'd1000, 32'd10, 32'd100, 33);

        // start re-pulsed mid-CALC with new operands must be ignored.
        start = 1'b1; funct3 = F3_DIVU; src_a = 32'd100; src_b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1; funct3 = F3_MUL; src_a = 32'd3; src_b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        ndone = 0; first_res = '0;
        for (int i = 0; i < 50; i++) begin
            if (done === 1'b1) begin
                if (ndone == 0) first_res = result;
                ndone++;
            end
            @(negedge clk);
        end
        chk("ignore_start_ndone", 64'(ndone), 64'd1);
        chk("ignore_start_result", {32'd0, first_res}, 64'd14);

        // Reset during CALC abandons the op.
        start = 1'b1; funct3 = F3_MUL; src_a = 32'h1234; src_b = 32'h10;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_result", {32'd0, result}, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) ndone++;
            @(negedge clk);
        end
        chk("midrst_no_done", 64'(ndone), 64'd0);
        chk("midrst_busy_after", {63'd0, busy}, 64'd0);
        op_idle("post_rst_mul", F3_MUL, 32'd3, 32'd4, 32'd12, 33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
